// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// writeback sources, PC select and controller state.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;

  typedef enum logic [1:0] {
    HC_INIT     = 2'b00,
    HC_RUN      = 2'b01,
    HC_MEM_WAIT = 2'b10,
    HC_ERR      = 2'b11
  } hc_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator: picks the M or W bypass for one source
// register and flags a load in M that this operand would consume too early.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_adr,
  input  logic          i_use,
  input  logic [AW-1:0] i_rdM,
  input  logic          i_reg_writeM,
  input  logic [1:0]    i_wb_selM,
  input  logic [AW-1:0] i_rdW,
  input  logic          i_reg_writeW,
  output logic [1:0]    o_fwd,
  output logic          o_load_match
);

  logic w_hitM;
  logic w_hitW;

  assign w_hitM = i_reg_writeM && (i_rdM != {AW{1'b0}}) && (i_rdM == i_adr);
  assign w_hitW = i_reg_writeW && (i_rdW != {AW{1'b0}}) && (i_rdW == i_adr);

  // A load result in M is not available yet, so it never wins the M bypass.
  always_comb begin
    o_fwd = FWD_RF;
    if (w_hitM && (i_wb_selM != WB_MEM)) begin
      o_fwd = FWD_M;
    end else if (w_hitW) begin
      o_fwd = FWD_W;
    end else begin
      o_fwd = FWD_RF;
    end
  end

  assign o_load_match = w_hitM && (i_wb_selM == WB_MEM) && i_use;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stalls, redirect
// flushes, dmem wait sequencing with timeout watchdog, and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(XLEN)-1:0]    adr1D,
  input  logic [$clog2(XLEN)-1:0]    adr2D,
  input  logic                       use_rs1D,
  input  logic                       use_rs2D,
  input  logic [1:0]                 pc_selD,
  input  logic [$clog2(XLEN)-1:0]    rdM,
  input  logic                       reg_writeM,
  input  logic [1:0]                 wb_selM,
  input  logic                       mem_accessM,
  input  logic                       dmem_ready,
  input  logic [$clog2(XLEN)-1:0]    rdW,
  input  logic                       reg_writeW,
  output logic [1:0]                 forward1D,
  output logic [1:0]                 forward2D,
  output logic                       stallF,
  output logic                       stallD,
  output logic                       flushD,
  output logic                       bubbleM,
  output logic                       stallM,
  output logic                       bubbleW,
  output logic                       mem_err,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int AW     = $clog2(XLEN);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  hc_state_e         r_state;
  hc_state_e         w_next;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_load1;
  logic              w_load2;
  logic              w_load_haz;
  logic              w_flush_inc;
  logic              w_mem_miss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  hazard_ctrl_fwd_sel #(.AW(AW)) u_fwd1 (
    .i_adr(adr1D), .i_use(use_rs1D), .i_rdM(rdM), .i_reg_writeM(reg_writeM),
    .i_wb_selM(wb_selM), .i_rdW(rdW), .i_reg_writeW(reg_writeW),
    .o_fwd(forward1D), .o_load_match(w_load1)
  );

  hazard_ctrl_fwd_sel #(.AW(AW)) u_fwd2 (
    .i_adr(adr2D), .i_use(use_rs2D), .i_rdM(rdM), .i_reg_writeM(reg_writeM),
    .i_wb_selM(wb_selM), .i_rdW(rdW), .i_reg_writeW(reg_writeW),
    .o_fwd(forward2D), .o_load_match(w_load2)
  );

  assign w_load_haz = w_load1 || w_load2;
  assign w_mem_miss = mem_accessM && !dmem_ready;

  // Pipeline controls and next state; priority in RUN is mem miss, load-use, redirect.
  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    flushD      = 1'b0;
    bubbleM     = 1'b0;
    stallM      = 1'b0;
    bubbleW     = 1'b0;
    w_flush_inc = 1'b0;
    w_next      = r_state;
    case (r_state)
      HC_INIT: begin
        stallF  = 1'b1;
        flushD  = 1'b1;
        bubbleM = 1'b1;
        w_next  = HC_RUN;
      end
      HC_RUN: begin
        if (w_mem_miss) begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          stallM  = 1'b1;
          bubbleW = 1'b1;
          w_next  = HC_MEM_WAIT;
        end else if (w_load_haz) begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          bubbleM = 1'b1;
        end else if (pc_selD != PC_SEQ) begin
          flushD      = 1'b1;
          w_flush_inc = 1'b1;
        end else begin
          w_next = HC_RUN;
        end
      end
      HC_MEM_WAIT: begin
        if (dmem_ready) begin
          w_next = HC_RUN;
        end else begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          stallM  = 1'b1;
          bubbleW = 1'b1;
          if (r_wait_cnt == WCNT_LAST) begin
            w_next = HC_ERR;
          end else begin
            w_next = HC_MEM_WAIT;
          end
        end
      end
      HC_ERR: begin
        stallF  = 1'b1;
        stallD  = 1'b1;
        stallM  = 1'b1;
        bubbleW = 1'b1;
        w_next  = HC_ERR;
      end
      default: begin
        w_next = HC_INIT;
      end
    endcase
  end

  // State, wait timer, sticky error and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HC_INIT;
      r_wait_cnt  <= {WCNT_W{1'b0}};
      r_mem_err   <= 1'b0;
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if ((r_state == HC_RUN) && w_mem_miss) begin
        r_wait_cnt <= WCNT_W'(1);
      end else if ((r_state == HC_MEM_WAIT) && !dmem_ready && (r_wait_cnt != WCNT_LAST)) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
      if (w_next == HC_ERR) begin
        r_mem_err <= 1'b1;
      end
      if (stallD) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_flush_inc) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (4-bit counters, timeout of 8).
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] adr1D, adr2D, rdM, rdW;
  logic       use_rs1D, use_rs2D, reg_writeM, mem_accessM, dmem_ready, reg_writeW;
  logic [1:0] pc_selD, wb_selM;
  logic [1:0] forward1D, forward2D;
  logic       stallF, stallD, flushD, bubbleM, stallM, bubbleW, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.XLEN(32), .CNT_W(CNT_W), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .adr1D(adr1D), .adr2D(adr2D), .use_rs1D(use_rs1D),
    .use_rs2D(use_rs2D), .pc_selD(pc_selD), .rdM(rdM), .reg_writeM(reg_writeM),
    .wb_selM(wb_selM), .mem_accessM(mem_accessM), .dmem_ready(dmem_ready),
    .rdW(rdW), .reg_writeW(reg_writeW), .forward1D(forward1D), .forward2D(forward2D),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .bubbleM(bubbleM),
    .stallM(stallM), .bubbleW(bubbleW), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    adr1D = 5'd0; adr2D = 5'd0; use_rs1D = 1'b0; use_rs2D = 1'b0;
    pc_selD = 2'b00; rdM = 5'd0; reg_writeM = 1'b0; wb_selM = 2'b00;
    mem_accessM = 1'b0; dmem_ready = 1'b0; rdW = 5'd0; reg_writeW = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({stallF, flushD, bubbleM, stallD, stallM, bubbleW} !== 6'b111000) begin
      fails++;
      $display("FAIL init_ctrl: got %b expected 111000", {stallF, flushD, bubbleM, stallD, stallM, bubbleW});
    end
    tests++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || mem_err !== 1'b0) begin
      fails++;
      $display("FAIL init_cnt: got %0d/%0d/%b expected 0/0/0", stall_cnt, flush_cnt, mem_err);
    end
    tick();
    tests++;
    if ({stallF, flushD, bubbleM, stallD, stallM, bubbleW} !== 6'b000000) begin
      fails++;
      $display("FAIL run_ctrl: got %b expected 000000", {stallF, flushD, bubbleM, stallD, stallM, bubbleW});
    end
  endtask

  task automatic test_forwarding();
    reg_writeM = 1'b1; rdM = 5'd5; wb_selM = 2'b00;
    reg_writeW = 1'b1; rdW = 5'd5; adr1D = 5'd5; use_rs1D = 1'b1;
    #1;
    tests++;
    if (forward1D !== 2'b10) begin
      fails++; $display("FAIL fwd_m: got %b expected 10", forward1D);
    end
    rdM = 5'd0; #1;
    tests++;
    if (forward1D !== 2'b01) begin
      fails++; $display("FAIL fwd_w_rd0: got %b expected 01", forward1D);
    end
    reg_writeW = 1'b0; #1;
    tests++;
    if (forward1D !== 2'b00) begin
      fails++; $display("FAIL fwd_rf: got %b expected 00", forward1D);
    end
    // load in M matching rs2 that is not read: W bypass, no stall
    rdM = 5'd9; wb_selM = 2'b01; rdW = 5'd9; reg_writeW = 1'b1;
    adr2D = 5'd9; use_rs2D = 1'b0; use_rs1D = 1'b0; #1;
    tests++;
    if (forward2D !== 2'b01 || stallD !== 1'b0) begin
      fails++; $display("FAIL fwd_load_skip: got %b/%b expected 01/0", forward2D, stallD);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    reg_writeM = 1'b1; rdM = 5'd7; wb_selM = 2'b01; use_rs2D = 1'b1; adr2D = 5'd7;
    #1;
    tests++;
    if ({stallF, stallD, bubbleM, stallM, flushD} !== 5'b11100) begin
      fails++; $display("FAIL load_stall: got %b expected 11100", {stallF, stallD, bubbleM, stallM, flushD});
    end
    tick();
    tests++;
    if (stall_cnt !== 4'd1) begin
      fails++; $display("FAIL load_cnt: got %0d expected 1", stall_cnt);
    end
    reg_writeM = 1'b0; rdM = 5'd0; wb_selM = 2'b00; rdW = 5'd7; reg_writeW = 1'b1;
    #1;
    tests++;
    if (forward2D !== 2'b01 || stallD !== 1'b0) begin
      fails++; $display("FAIL load_fwd_w: got %b/%b expected 01/0", forward2D, stallD);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_load_vs_redirect();
    reg_writeM = 1'b1; rdM = 5'd7; wb_selM = 2'b01; use_rs2D = 1'b1; adr2D = 5'd7;
    pc_selD = 2'b01;
    #1;
    tests++;
    if (stallD !== 1'b1 || flushD !== 1'b0) begin
      fails++; $display("FAIL ldred_prio: got stallD=%b flushD=%b expected 1/0", stallD, flushD);
    end
    tick();
    tests++;
    if (flush_cnt !== 4'd0 || stall_cnt !== 4'd2) begin
      fails++; $display("FAIL ldred_cnt: got %0d/%0d expected 0/2", flush_cnt, stall_cnt);
    end
    idle_inputs(); pc_selD = 2'b01;
    #1;
    tests++;
    if (flushD !== 1'b1 || stallF !== 1'b0 || stallD !== 1'b0) begin
      fails++; $display("FAIL redirect: got flushD=%b stallF=%b stallD=%b expected 1/0/0", flushD, stallF, stallD);
    end
    tick();
    tests++;
    if (flush_cnt !== 4'd1) begin
      fails++; $display("FAIL redirect_cnt: got %0d expected 1", flush_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    int stall_cycles;
    do_reset();
    stall_cycles = 0;
    mem_accessM = 1'b1; dmem_ready = 1'b0;
    // hazard inputs held too: the miss must take priority and the release cycle ignores them
    reg_writeM = 1'b1; rdM = 5'd7; wb_selM = 2'b01; use_rs1D = 1'b1; adr1D = 5'd7;
    pc_selD = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (stallM === 1'b1 && bubbleW === 1'b1 && stallD === 1'b1 && flushD === 1'b0 && bubbleM === 1'b0) begin
        stall_cycles++;
      end
      tick();
    end
    tests++;
    if (stall_cycles !== 5) begin
      fails++; $display("FAIL mem_stall_cycles: got %0d expected 5", stall_cycles);
    end
    dmem_ready = 1'b1;
    #1;
    tests++;
    if ({stallF, stallD, stallM, bubbleW, bubbleM, flushD} !== 6'b000000) begin
      fails++; $display("FAIL mem_release: got %b expected 000000", {stallF, stallD, stallM, bubbleW, bubbleM, flushD});
    end
    tick();
    idle_inputs(); pc_selD = 2'b01;
    #1;
    tests++;
    if (flushD !== 1'b1 || mem_err !== 1'b0 || stall_cnt !== 4'd5 || flush_cnt !== 4'd0) begin
      fails++; $display("FAIL mem_after: got flushD=%b err=%b stall_cnt=%0d flush_cnt=%0d expected 1/0/5/0", flushD, mem_err, stall_cnt, flush_cnt);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    int early_err;
    do_reset();
    early_err = 0;
    mem_accessM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_err !== 1'b0) early_err++;
      tick();
    end
    tests++;
    if (early_err !== 0) begin
      fails++; $display("FAIL timeout_early: got %0d early cycles expected 0", early_err);
    end
    tests++;
    if (mem_err !== 1'b1 || {stallF, stallD, stallM, bubbleW} !== 4'b1111) begin
      fails++; $display("FAIL timeout_err: got err=%b ctrl=%b expected 1/1111", mem_err, {stallF, stallD, stallM, bubbleW});
    end
    dmem_ready = 1'b1;
    repeat (10) tick();
    tests++;
    if (mem_err !== 1'b1 || stallM !== 1'b1 || stall_cnt !== 4'd15) begin
      fails++; $display("FAIL err_sticky: got err=%b stallM=%b stall_cnt=%0d expected 1/1/15", mem_err, stallM, stall_cnt);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (mem_err !== 1'b0 || stall_cnt !== 4'd0 || stallF !== 1'b1 || flushD !== 1'b1 || stallM !== 1'b0) begin
      fails++; $display("FAIL err_reset: got err=%b cnt=%0d stallF=%b flushD=%b stallM=%b expected 0/0/1/1/0", mem_err, stall_cnt, stallF, flushD, stallM);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_flush_saturate();
    do_reset();
    pc_selD = 2'b10;
    repeat (20) tick();
    tests++;
    if (flush_cnt !== 4'd15 || stall_cnt !== 4'd0) begin
      fails++; $display("FAIL flush_sat: got %0d/%0d expected 15/0", flush_cnt, stall_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_load_vs_redirect();
    test_mem_wait();
    test_timeout();
    test_flush_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
